// File: rtl/popcount_mac_ctrl.sv
// ---------------------------------------------------------------------------
// popcount_mac_ctrl
//
// Sequencer for the 16-lane popcount datapath in bit-serial dot-product mode.
// Each operation requests IN_BITS bit-planes from the array, MSB plane first.
// Every plane is reduced to a 0..16 popcount, and the counts are combined by
// shift-add into a dot product. When SIGNED=1 the MSB plane carries negative
// weight, so the result is two's complement. A single-cycle done pulse marks
// a new result.
//
// Parameters
//   IN_BITS : bit-planes per operation (1..8)
//   ACC_W   : accumulator / result width (>= IN_BITS+5, so it cannot overflow)
//   SIGNED  : 1 = MSB plane is subtracted (two's-complement activations)
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : synchronous active-high reset
//   start      : begin an operation (only looked at while idle)
//   busy       : high from the first request cycle through the done cycle
//   plane_req  : request for bit-plane plane_idx
//   plane_idx  : index of the plane being requested (IN_BITS-1 down to 0)
//   plane_vld  : plane_data valid; a transfer happens on plane_req & plane_vld
//   plane_data : 16-lane bit-plane (activation bit AND weight per lane)
//   done       : one-cycle pulse, result is valid
//   result     : dot product, held until the next operation completes
// ---------------------------------------------------------------------------
module popcount_mac_ctrl #(
    parameter int IN_BITS = 4,
    parameter int ACC_W   = 12,
    parameter int SIGNED  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             plane_req,
    output logic [2:0]       plane_idx,
    input  logic             plane_vld,
    input  logic [15:0]      plane_data,
    output logic             done,
    output logic [ACC_W-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] TOP_IDX = 3'(IN_BITS - 1);

    state_t           state_q;
    logic [2:0]       idx_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [4:0]       pc_q;
    logic [ACC_W-1:0] pc_ext;
    logic             busy_q;
    logic             req_q;
    logic [2:0]       pidx_q;
    logic             done_q;
    logic [ACC_W-1:0] result_q;

    // Full 5-bit count: 16 set lanes must give 16, not wrap to 0.
    function automatic logic [4:0] popcount16(input logic [15:0] d);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(d[i]);
        end
        return cnt;
    endfunction

    // Shift-add step. The first (MSB) plane seeds the accumulator, negated
    // when the MSB carries negative weight; later planes double what is
    // there and add their count. Depends only on registered state, so
    // plane_vld has no path to any output.
    always_comb begin
        pc_ext = {{(ACC_W-5){1'b0}}, pc_q};
        acc_d  = '0;
        if (idx_q == TOP_IDX) begin
            if (SIGNED != 0) begin
                acc_d = -pc_ext;
            end else begin
                acc_d = pc_ext;
            end
        end else begin
            acc_d = (acc_q << 1) + pc_ext;
        end
    end

    // Controller: all outputs are registered and updated together with the
    // state so that they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            pc_q     <= '0;
            busy_q   <= 1'b0;
            req_q    <= 1'b0;
            pidx_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= REQ;
                        idx_q   <= TOP_IDX;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        req_q   <= 1'b1;
                        pidx_q  <= TOP_IDX;
                    end
                end

                REQ: begin
                    // plane_req is high throughout REQ, so plane_vld alone
                    // completes the handshake; plane_idx stays put while waiting.
                    if (plane_vld) begin
                        pc_q    <= popcount16(plane_data);
                        req_q   <= 1'b0;
                        state_q <= ACC;
                    end
                end

                ACC: begin
                    acc_q <= acc_d;
                    if (idx_q == 3'd0) begin
                        result_q <= acc_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        idx_q   <= idx_q - 3'd1;
                        pidx_q  <= idx_q - 3'd1;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end

                DONE: begin
                    // start is deliberately not looked at here; the earliest
                    // new operation begins from the following IDLE cycle.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign plane_req = req_q;
    assign plane_idx = pidx_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_popcount_mac_ctrl.sv
// ---------------------------------------------------------------------------
// tb_popcount_mac_ctrl
//
// Directed bench for popcount_mac_ctrl. Two instances (unsigned and signed,
// IN_BITS=4, ACC_W=12) share clock and stimulus, so every operation yields an
// unsigned and a two's-complement result from the same bit-planes. Expected
// values below are hand-computed from the shift-add definition.
// ---------------------------------------------------------------------------
module tb_popcount_mac_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        plane_vld;
    logic [15:0] plane_data;

    logic        busy_u, req_u, done_u;
    logic [2:0]  idx_u;
    logic [11:0] res_u;
    logic        busy_s, req_s, done_s;
    logic [2:0]  idx_s;
    logic [11:0] res_s;

    logic [11:0] prev_u = '0;
    logic [11:0] prev_s = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    popcount_mac_ctrl #(.IN_BITS(4), .ACC_W(12), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy_u), .plane_req(req_u), .plane_idx(idx_u),
        .plane_vld(plane_vld), .plane_data(plane_data),
        .done(done_u), .result(res_u)
    );

    popcount_mac_ctrl #(.IN_BITS(4), .ACC_W(12), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy_s), .plane_req(req_s), .plane_idx(idx_s),
        .plane_vld(plane_vld), .plane_data(plane_data),
        .done(done_s), .result(res_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One operation. Cycle k=1 is the first cycle after the edge that sees
    // start. Planes are served in request order; plane wplane is withheld for
    // wcyc cycles. With poke set, start is pulsed while busy and in DONE.
    task automatic run_op(input string tag,
                          input logic [15:0] p3, input logic [15:0] p2,
                          input logic [15:0] p1, input logic [15:0] p0,
                          input int wplane, input int wcyc, input bit poke,
                          input logic [11:0] exp_u, input logic [11:0] exp_s,
                          input int exp_done);
        logic [15:0] pl [4];
        int waited;
        int exp_idx;
        int ndone;
        pl[3] = p3; pl[2] = p2; pl[1] = p1; pl[0] = p0;
        waited  = 0;
        exp_idx = 3;
        ndone   = 0;

        @(negedge clk);
        start      = 1'b1;
        plane_vld  = 1'b1;
        plane_data = 16'h5A5A;
        @(negedge clk);
        for (int k = 1; k <= 22; k++) begin
            start = 1'b0;
            if (k == 1) begin
                check({tag, ".hold_u"}, 32'(res_u), 32'(prev_u));
                check({tag, ".hold_s"}, 32'(res_s), 32'(prev_s));
            end
            check({tag, ".busy"}, 32'(busy_u), 32'(k <= exp_done));
            check({tag, ".done_u"}, 32'(done_u), 32'(k == exp_done));
            check({tag, ".done_s"}, 32'(done_s), 32'(k == exp_done));
            if (done_u) ndone++;
            if (req_u) begin
                check({tag, ".idx"}, 32'(idx_u), 32'(exp_idx));
                if (int'(idx_u) == wplane && waited < wcyc) begin
                    plane_vld  = 1'b0;
                    plane_data = 16'hA5A5;
                    waited++;
                end else begin
                    plane_vld  = 1'b1;
                    plane_data = (exp_idx >= 0) ? pl[exp_idx] : 16'h5A5A;
                    exp_idx--;
                end
            end else begin
                // Valid outside REQ must be ignored.
                plane_vld  = 1'b1;
                plane_data = 16'h5A5A;
            end
            if (poke && (k == 3 || k == exp_done)) start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, ".ndone"}, 32'(ndone), 32'd1);
        check({tag, ".planes"}, 32'(exp_idx), 32'hFFFF_FFFF);
        check({tag, ".res_u"}, 32'(res_u), 32'(exp_u));
        check({tag, ".res_s"}, 32'(res_s), 32'(exp_s));
        check({tag, ".idle"}, 32'(busy_u | busy_s), 32'd0);
        prev_u = exp_u;
        prev_s = exp_s;
    endtask

    // Abort an operation during the ACC cycle of plane 1, then confirm the
    // outputs are cleared and no done follows.
    task automatic reset_mid_op();
        int ndone;
        ndone = 0;
        @(negedge clk);
        start      = 1'b1;
        plane_vld  = 1'b1;
        plane_data = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        // Cycle 6: ACC for plane 1.
        check("rst_mid.in_acc_req", 32'(req_u), 32'd0);
        check("rst_mid.in_acc_idx", 32'(idx_u), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid.busy", 32'(busy_u | busy_s), 32'd0);
        check("rst_mid.req", 32'(req_u | req_s), 32'd0);
        check("rst_mid.idx", 32'(idx_u | idx_s), 32'd0);
        check("rst_mid.done", 32'(done_u | done_s), 32'd0);
        check("rst_mid.res_u", 32'(res_u), 32'd0);
        check("rst_mid.res_s", 32'(res_s), 32'd0);
        for (int k = 0; k < 12; k++) begin
            if (done_u || done_s || busy_u) ndone++;
            @(negedge clk);
        end
        check("rst_mid.no_done", 32'(ndone), 32'd0);
        prev_u = '0;
        prev_s = '0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        plane_vld  = 1'b0;
        plane_data = '0;
        repeat (2) @(negedge clk);
        check("reset.busy", 32'(busy_u | busy_s), 32'd0);
        check("reset.req", 32'(req_u | req_s), 32'd0);
        check("reset.idx", 32'(idx_u | idx_s), 32'd0);
        check("reset.done", 32'(done_u | done_s), 32'd0);
        check("reset.res_u", 32'(res_u), 32'd0);
        check("reset.res_s", 32'(res_s), 32'd0);
        rst = 1'b0;

        // Every lane set: unsigned 16*15=240, signed -16.
        run_op("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0, 1'b0,
               12'h0F0, 12'hFF0, 9);
        // Counts 8,0,16,1: unsigned 97, signed -64+0+32+1 = -31.
        run_op("mixed", 16'h00FF, 16'h0000, 16'hFFFF, 16'h0001, -1, 0, 1'b0,
               12'h061, 12'hFE1, 9);
        // One lane on the MSB plane: unsigned 8, signed -8.
        run_op("msb1", 16'h8000, 16'h0000, 16'h0000, 16'h0000, -1, 0, 1'b0,
               12'h008, 12'hFF8, 9);
        // Plane 2 held back three cycles: same result, done three cycles later.
        run_op("bp", 16'h00FF, 16'h0000, 16'hFFFF, 16'h0001, 2, 3, 1'b0,
               12'h061, 12'hFE1, 12);
        // start pulsed while busy and in DONE must not queue another op.
        run_op("poke", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, -1, 0, 1'b1,
               12'h0F0, 12'hFF0, 9);

        reset_mid_op();
        run_op("after_rst", 16'h00FF, 16'h0000, 16'hFFFF, 16'h0001, -1, 0, 1'b0,
               12'h061, 12'hFE1, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/popcount_mac_ctrl.md
# popcount_mac_ctrl

Sequencer for the 16-input popcount datapath in bit-serial dot-product mode. It requests one 16-bit bit-plane at a time from the array, MSB plane first, and popcounts each plane to a 0..16 count. Counts are accumulated with shift-add, and the signed or unsigned dot-product result is presented with a one-cycle done pulse. It sits between the array read path and the output/writeback logic.

## Interface
- IN_BITS, 4, activation precision = number of bit-planes per operation; legal 1..8
- ACC_W, 12, accumulator/result width; must be >= IN_BITS+5
- SIGNED, 0, 1 = MSB plane carries negative weight (two's-complement activations)
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begin an operation; sampled only in IDLE
- busy  output  1  high from first REQ cycle through DONE cycle inclusive
- plane_req  output  1  request for plane plane_idx
- plane_idx  output  3  plane being requested, IN_BITS-1 down to 0
- plane_vld  input  1  plane_data valid; handshake = plane_req & plane_vld
- plane_data  input  16  bit-plane (activation bit AND weight per lane)
- done  output  1  one-cycle pulse, result valid
- result  output  ACC_W  dot product; two's complement when SIGNED=1

## Operation
- Popcount of plane_data is 5 bits wide (0..16). It is zero-extended to ACC_W before accumulation; no truncation is allowed at any level.
- FSM states are IDLE, REQ, ACC, DONE.
- IDLE: start=1 -> REQ. Side effects: idx <= IN_BITS-1, acc <= 0.
- REQ: plane_req=1 and plane_idx=idx.
  - On handshake, pc_q <= popcount(plane_data) and the FSM moves to ACC.
  - Without handshake, the FSM stays in REQ with plane_idx stable.
- ACC:
  - First plane (idx=IN_BITS-1): acc <= -pc_q if SIGNED=1, else acc <= pc_q.
  - Other planes: acc <= (acc<<1) + pc_q.
  - If idx=0: result <= new acc value and the FSM moves to DONE.
  - Otherwise: idx <= idx-1 and the FSM moves to REQ.
- DONE: done=1 for exactly one cycle, then IDLE.
- plane_vld outside REQ is ignored; plane_data is sampled only on the handshake cycle.
- start while busy is ignored and does not queue.
- start in the DONE cycle is ignored; start is accepted from IDLE on the next cycle.
- result holds its value until the final ACC of the next operation; it is not cleared at start.
- Arithmetic is modulo 2^ACC_W. With ACC_W >= IN_BITS+5, overflow is impossible:
  - unsigned max = 16*(2^IN_BITS-1);
  - signed range = -16*2^(IN_BITS-1) .. 16*(2^(IN_BITS-1)-1).
- IN_BITS=1: a single REQ/ACC pair.
  - SIGNED=1 gives result = -popcount.

## Timing
- Reset (rst=1 at an edge) forces state=IDLE and sets the following to 0: busy, plane_req, plane_idx, done, result, acc, pc_q, idx.
- Reset mid-operation aborts immediately; no done is produced for the aborted operation.
- start seen at edge t (IDLE) -> REQ during cycle t+1.
- Each plane costs 1+W cycles in REQ, where W = wait cycles before plane_vld, plus 1 cycle in ACC.
- With plane_vld tied high: done high in cycle t+2*IN_BITS+1. For IN_BITS=4, that is cycle t+9.
- busy falls in the cycle after DONE; next accepted start is earliest in that IDLE cycle.
- All outputs are registered or decoded from state only; no combinational path from plane_vld to any output.

## Test plan
- Unsigned max: IN_BITS=4, SIGNED=0, plane_vld=1, all planes 0xFFFF -> plane_idx sequence 3,2,1,0; result=240 (0x0F0); done single-cycle at t+9.
- Unsigned mixed: planes 3..0 = 0x00FF, 0x0000, 0xFFFF, 0x0001 -> result=97.
- Signed: SIGNED=1, all planes 0xFFFF -> result=0xFF0 (-16).
- Signed single-bit: SIGNED=1, planes 0x8000, 0x0000, 0x0000, 0x0000 -> result=0xFF8 (-8).
- Backpressure: plane_vld withheld 3 cycles on plane 2 -> plane_req/plane_idx=2 held stable; done at t+12.
- Result unchanged versus the zero-wait case.
- start pulses during busy and in DONE -> ignored; exactly one done per accepted start.
- Reset mid-op: rst asserted while in ACC for plane 1 -> next cycle all outputs 0; no done.
- A following start completes normally with a correct result.
